// File: rtl/bt_pkg.sv
// bt_pkg: shared state encoding, ASCII codes and command IDs for the Bluetooth command scheduler
package bt_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;
    localparam logic [7:0] CH_A = 8'h41, CH_T = 8'h54, CH_Z = 8'h5A, CH_D = 8'h44;
    localparam logic [7:0] CH_H = 8'h48, CH_PLUS = 8'h2B, CH_CR = 8'h0D;
    localparam int CMD_ATZ = 0, CMD_ATD = 1, CMD_ESC = 2, CMD_ATH = 3;
    localparam int DEF_CLK_DIV = 1000;
endpackage

// File: rtl/bt_cmd_sched_if.sv
// bt_cmd_sched_if: requester handshake plus UART line; BT_CMD_SCHED_ABORT_EN adds abort/aborted
interface bt_cmd_sched_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic done;
    logic busy;
    logic BT_Tx;
`ifdef BT_CMD_SCHED_ABORT_EN
    logic abort;
    logic aborted;
    modport master (output req, abort, input grant, done, busy, BT_Tx, aborted);
    modport slave (input req, abort, output grant, done, busy, BT_Tx, aborted);
`else
    modport master (output req, input grant, done, busy, BT_Tx);
    modport slave (input req, output grant, done, busy, BT_Tx);
`endif
endinterface

// File: rtl/bt_cmd_rom.sv
// bt_cmd_rom: fixed AT command strings, one per requester; returns the indexed character and command length
module bt_cmd_rom import bt_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int MAX_LEN = 8
) (
    input  logic [$clog2(N_REQ)-1:0]     cmd,
    input  logic [$clog2(MAX_LEN)-1:0]   idx,
    output logic [7:0]                   chr,
    output logic [$clog2(MAX_LEN+1)-1:0] len
);
    localparam int LW = $clog2(MAX_LEN + 1);
    always_comb begin
        chr = CH_CR;
        len = LW'(4);
        case (int'(cmd))
            CMD_ATZ: chr = idx == 0 ? CH_A : idx == 1 ? CH_T : idx == 2 ? CH_Z : CH_CR;
            CMD_ATD: chr = idx == 0 ? CH_A : idx == 1 ? CH_T : idx == 2 ? CH_D : CH_CR;
            CMD_ESC: begin
                chr = CH_PLUS;
                len = LW'(3);
            end
            CMD_ATH: chr = idx == 0 ? CH_A : idx == 1 ? CH_T : idx == 2 ? CH_H : CH_CR;
            default: len = LW'(1);
        endcase
    end
endmodule

// File: rtl/bt_cmd_sched.sv
// bt_cmd_sched: round-robin scheduler sending one fixed AT command per grant over 8N1 UART, then a guard gap.
// Optional BT_CMD_SCHED_ABORT_EN: abort skips remaining characters after the current one.
module bt_cmd_sched import bt_pkg::*; #(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int N_REQ = 4,
    parameter int GUARD_BITS = 20,
    parameter int MAX_LEN = 8
) (
    input logic CLOCK_10,
    input logic reset,
    bt_cmd_sched_if.slave b
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int CW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(N_REQ);
    localparam int GW = $clog2(GUARD_BITS * CLK_DIV + 1);
    localparam int GLAST = GUARD_BITS * CLK_DIV - 1;
    state_t state;
    logic [DW-1:0] div_cnt;
    logic [3:0] bit_idx;
    logic [CW-1:0] char_idx;
    logic [GW-1:0] g_cnt;
    logic [IW-1:0] rr_ptr, win, j;
    logic [7:0] chr;
    logic [LW-1:0] len;
    logic tick, more, stop, fin;
    bt_cmd_rom #(.N_REQ(N_REQ), .MAX_LEN(MAX_LEN)) rom (.cmd(rr_ptr), .idx(char_idx), .chr(chr), .len(len));
    assign tick = div_cnt == DW'(CLK_DIV - 1);
    assign more = LW'(char_idx) + LW'(1) < len;
    assign fin = state == GUARD && g_cnt == GW'(GLAST);
    // descending scan so the nearest set bit after rr_ptr is the last to be assigned
    always_comb begin
        win = rr_ptr;
        j = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = IW'((int'(rr_ptr) + k) % N_REQ);
            if (b.req[j]) win = j;
        end
    end
`ifdef BT_CMD_SCHED_ABORT_EN
    logic abort_flag;
    assign stop = abort_flag | b.abort;
    always_ff @(posedge CLOCK_10) begin
        if (reset) begin
            abort_flag <= 1'b0;
            b.aborted <= 1'b0;
        end else begin
            abort_flag <= fin ? 1'b0 : abort_flag | (state == SHIFT && b.abort);
            b.aborted <= fin & abort_flag;
        end
    end
`else
    assign stop = 1'b0;
`endif
    always_ff @(posedge CLOCK_10) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= IW'(N_REQ - 1);
            b.grant <= '0;
            b.done <= 1'b0;
            b.busy <= 1'b0;
            b.BT_Tx <= 1'b1;
            div_cnt <= '0;
            bit_idx <= '0;
            char_idx <= '0;
            g_cnt <= '0;
        end else begin
            b.done <= 1'b0;
            case (state)
                IDLE: if (|b.req) begin
                    state <= SHIFT;
                    rr_ptr <= win;
                    b.grant <= N_REQ'(1) << win;
                    b.busy <= 1'b1;
                    b.BT_Tx <= 1'b0;
                    div_cnt <= '0;
                    bit_idx <= '0;
                    char_idx <= '0;
                end
                SHIFT: begin
                    div_cnt <= tick ? '0 : div_cnt + DW'(1);
                    if (tick) begin
                        if (bit_idx < 4'd9) begin
                            bit_idx <= bit_idx + 4'd1;
                            b.BT_Tx <= bit_idx == 4'd8 ? 1'b1 : chr[bit_idx[2:0]];
                        end else if (more && !stop) begin
                            char_idx <= char_idx + CW'(1);
                            bit_idx <= '0;
                            b.BT_Tx <= 1'b0;
                        end else begin
                            state <= GUARD;
                            b.BT_Tx <= 1'b1;
                            g_cnt <= '0;
                        end
                    end
                end
                GUARD: if (fin) begin
                    state <= IDLE;
                    b.done <= 1'b1;
                    b.grant <= '0;
                    b.busy <= 1'b0;
                end else begin
                    g_cnt <= g_cnt + GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bt_cmd_sched.sv
// tb_bt_cmd_sched: table-driven arbitration vectors with a scoreboard checked by a UART-decoding monitor
module tb_bt_cmd_sched;
    localparam int CD = 4;
    localparam int GB = 2;
    typedef struct { logic [3:0] req; logic [3:0] after; int id; } vec_t;
    typedef struct { int id; int nch; bit ab; bit gap; } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0, failures = 0;
    int cyc = 0, t = 0, last_done = -1, bad_g = 0, bad_busy = 0;
    bit in_tx = 1'b0;
    logic [3:0] g;
    logic [63:0] got;
    exp_t sb[$];
    exp_t e;
    vec_t vec[12];
    string cmds[4] = '{"ATZ\015", "ATD\015", "+++", "ATH\015"};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    bt_cmd_sched_if #(.N_REQ(4)) bus ();
    bt_cmd_sched #(.CLK_DIV(CD), .N_REQ(4), .GUARD_BITS(GB), .MAX_LEN(8)) dut (
        .CLOCK_10(clk), .reset(reset), .b(bus)
    );

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [63:0] frame(int id, int nch);
        logic [63:0] v;
        logic [7:0] ch;
        v = '0;
        for (int c = 0; c < nch; c++) begin
            ch = cmds[id][c];
            v = {v[62:0], 1'b0};
            for (int i = 0; i < 8; i++) v = {v[62:0], ch[i]};
            v = {v[62:0], 1'b1};
        end
        for (int k = 0; k < GB; k++) v = {v[62:0], 1'b1};
        return v;
    endfunction

    // call just after a negedge; returns at negedge+1 of the first grant cycle
    task automatic start_tx(logic [3:0] r, logic [3:0] after, int id, int nch, bit ab);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n == 500) chk("idle_timeout", 0, 1);
        #1 bus.req = r;
        sb.push_back('{id: id, nch: nch, ab: ab, gap: n > 0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.grant === 4'b0 && n < 50);
        chk("granted", bus.grant != 4'b0, 1);
        #1 bus.req = after;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            in_tx = 1'b0;
            last_done = -1;
            sb.delete();
        end else begin
            if (!in_tx && bus.grant != 4'b0) begin
                in_tx = 1'b1;
                t = 0;
                g = bus.grant;
                got = '0;
                bad_g = 0;
                bad_busy = 0;
                if (sb.size() > 0 && sb[0].gap) chk("gap", cyc - last_done, 1);
            end
            if (bus.done) begin
                chk("done_in_tx", in_tx, 1);
                if (sb.size() == 0) chk("sb_empty", 0, 1);
                else begin
                    e = sb.pop_front();
                    chk("grant", g, 4'b1 << e.id);
                    chk("len", t + 1, 1 + e.nch * 10 * CD + GB * CD);
                    chk("bits", got, frame(e.id, e.nch));
                    chk("grant_hold", bad_g, 0);
                    chk("busy_hold", bad_busy, 0);
`ifdef BT_CMD_SCHED_ABORT_EN
                    chk("aborted", bus.aborted, e.ab);
`endif
                end
                chk("done_outs", {bus.grant, bus.busy, bus.BT_Tx}, 6'b000001);
                in_tx = 1'b0;
                last_done = cyc;
            end else if (in_tx) begin
                if (bus.grant !== g) bad_g++;
                if (bus.busy !== 1'b1) bad_busy++;
                if (t % CD == CD / 2) got = {got[62:0], bus.BT_Tx};
                t++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{4'b1111, 4'b1111, 0};
        vec[1]  = '{4'b1111, 4'b1111, 1};
        vec[2]  = '{4'b1111, 4'b1111, 2};
        vec[3]  = '{4'b1111, 4'b1111, 3};
        vec[4]  = '{4'b1111, 4'b1111, 0};
        vec[5]  = '{4'b0100, 4'b0011, 2};
        vec[6]  = '{4'b0011, 4'b0000, 0};
        vec[7]  = '{4'b0011, 4'b0000, 1};
        vec[8]  = '{4'b1001, 4'b0000, 3};
        vec[9]  = '{4'b1001, 4'b0000, 0};
        vec[10] = '{4'b0001, 4'b0000, 0};
        vec[11] = '{4'b1010, 4'b0000, 1};
        bus.req = 4'b0;
`ifdef BT_CMD_SCHED_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tx", bus.BT_Tx, 1);
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) start_tx(vec[i].req, vec[i].after, vec[i].id, cmds[vec[i].id].len(), 1'b0);
        // interrupt a transaction with reset at its 50th cycle
        start_tx(4'b0001, 4'b0001, 0, 4, 1'b0);
        repeat (49) @(negedge clk);
        #1 reset = 1'b1;
        bus.req = 4'b0;
        @(negedge clk);
        chk("rst_mid", {bus.grant, bus.busy, bus.done, bus.BT_Tx}, 7'b0000001);
        #1 reset = 1'b0;
        @(negedge clk);
        start_tx(4'b1111, 4'b0000, 0, 4, 1'b0);
`ifdef BT_CMD_SCHED_ABORT_EN
        start_tx(4'b0010, 4'b0000, 1, 2, 1'b1);
        repeat (53) @(negedge clk);
        #1 bus.abort = 1'b1;
        @(negedge clk);
        #1 bus.abort = 1'b0;
        start_tx(4'b0100, 4'b0000, 2, 3, 1'b0);
        repeat (122) @(negedge clk);
        #1 bus.abort = 1'b1;
        @(negedge clk);
        #1 bus.abort = 1'b0;
        start_tx(4'b1000, 4'b0000, 3, 4, 1'b0);
`endif
        for (int n = 0; n < 500 && bus.busy !== 1'b0; n++) @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
